// File: rtl/imem_program_loader.sv
// Byte-stream program loader: assembles little-endian words from a header/payload/checksum
// stream, writes them into instruction memory and releases core reset once the image checks out.
module imem_program_loader #(
  parameter int                   BIT_COUNT  = 32,
  parameter int                   IMEM_WORDS = 1024,
  parameter logic [BIT_COUNT-1:0] BASE_ADDR  = 32'h0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  input  logic                 restart,
  output logic                 imem_we,
  output logic [BIT_COUNT-1:0] imem_adr,
  output logic [BIT_COUNT-1:0] imem_wdata,
  output logic                 core_reset,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    S_HDR0 = 3'd0,
    S_HDR1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_count;
  logic [15:0] r_word_idx;
  logic [1:0]  r_byte_idx;
  logic [7:0]  r_csum;
  logic [23:0] r_word;

  logic        w_accept;
  logic        w_last_byte;
  logic        w_last_word;
  logic        w_restart;
  logic [15:0] w_n;

  // in_ready is a pure state decode, gated low while the async reset is asserted
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      in_ready = 1'b0;
    end else begin
      case (r_state)
        S_HDR0, S_HDR1, S_DATA, S_CSUM: in_ready = 1'b1;
        default:                        in_ready = 1'b0;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_HDR0;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    w_accept     = in_valid & in_ready;
    w_n          = {in_data, r_count[7:0]};
    w_last_byte  = (r_byte_idx == 2'd3);
    w_last_word  = (r_word_idx == (r_count - 16'd1));
    w_restart    = 1'b0;
    case (r_state)
      S_HDR0: begin
        if (w_accept) w_next_state = S_HDR1;
        else          w_next_state = S_HDR0;
      end
      S_HDR1: begin
        if (!w_accept)                         w_next_state = S_HDR1;
        else if ({16'd0, w_n} > 32'(IMEM_WORDS)) w_next_state = S_ERR;
        else if (w_n == 16'd0)                 w_next_state = S_CSUM;
        else                                   w_next_state = S_DATA;
      end
      S_DATA: begin
        if (w_accept && w_last_byte && w_last_word) w_next_state = S_CSUM;
        else                                        w_next_state = S_DATA;
      end
      S_CSUM: begin
        if (!w_accept)             w_next_state = S_CSUM;
        else if (in_data == r_csum) w_next_state = S_DONE;
        else                        w_next_state = S_ERR;
      end
      S_DONE, S_ERR: begin
        if (restart) begin
          w_next_state = S_HDR0;
          w_restart    = 1'b1;
        end else begin
          w_next_state = r_state;
        end
      end
      default: w_next_state = S_HDR0;
    endcase
  end

  // Datapath: header capture, word assembly, memory write and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count    <= 16'd0;
      r_word_idx <= 16'd0;
      r_byte_idx <= 2'd0;
      r_csum     <= 8'd0;
      r_word     <= 24'd0;
      imem_we    <= 1'b0;
      imem_adr   <= BASE_ADDR;
      imem_wdata <= {BIT_COUNT{1'b0}};
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we    <= 1'b0;
      done       <= (w_next_state == S_DONE);
      error      <= (w_next_state == S_ERR);
      core_reset <= (w_next_state != S_DONE);
      if (w_restart) begin
        r_count    <= 16'd0;
        r_word_idx <= 16'd0;
        r_byte_idx <= 2'd0;
        r_csum     <= 8'd0;
        r_word     <= 24'd0;
      end else if (w_accept) begin
        case (r_state)
          S_HDR0: r_count[7:0]  <= in_data;
          S_HDR1: r_count[15:8] <= in_data;
          S_DATA: begin
            r_csum     <= r_csum + in_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0: r_word[7:0]   <= in_data;
              2'd1: r_word[15:8]  <= in_data;
              2'd2: r_word[23:16] <= in_data;
              default: begin
                // Fourth byte completes the word; commit it on the following cycle
                imem_we    <= 1'b1;
                imem_wdata <= BIT_COUNT'({in_data, r_word});
                imem_adr   <= BASE_ADDR + BIT_COUNT'({r_word_idx, 2'b00});
                r_word_idx <= r_word_idx + 16'd1;
              end
            endcase
          end
          default: r_csum <= r_csum;
        endcase
      end else begin
        r_csum <= r_csum;
      end
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: stream loads, checksum errors, oversize headers,
// handshake bubbles and asynchronous reset mid-load.
module tb_imem_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        restart;
  logic        imem_we;
  logic [31:0] imem_adr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int we_double = 0;
  logic prev_we = 1'b0;
  logic [63:0] wr_q[$];
  logic [7:0]  stream[$];

  imem_program_loader #(.BIT_COUNT(32), .IMEM_WORDS(1024), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .restart(restart), .imem_we(imem_we), .imem_adr(imem_adr), .imem_wdata(imem_wdata),
    .core_reset(core_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) wr_q.push_back({imem_adr, imem_wdata});
    if (imem_we && prev_we) we_double <= we_double + 1;
    prev_we <= imem_we;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_byte timeout: in_ready=%0b required 1 for byte %h", in_ready, b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_stream(input int first, input int last, input bit bubbles);
    for (int i = first; i <= last; i++) begin
      send_byte(stream[i]);
      if (bubbles) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic load_good_stream();
    stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hF6};
  endtask

  task automatic check_two_writes(input string tag);
    checks++;
    if (wr_q.size() !== 2) begin
      errors++;
      $display("FAIL %s write_count: got %0d required 2", tag, wr_q.size());
    end else begin
      checks++;
      if (wr_q[0] !== {32'h0000_0000, 32'h0050_0093}) begin
        errors++;
        $display("FAIL %s write0: got %h required %h", tag, wr_q[0], {32'h0, 32'h0050_0093});
      end
      checks++;
      if (wr_q[1] !== {32'h0000_0004, 32'h0000_0013}) begin
        errors++;
        $display("FAIL %s write1: got %h required %h", tag, wr_q[1], {32'h4, 32'h0000_0013});
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; restart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, imem_we, core_reset, done, error} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_flags: got rdy/we/crst/done/err=%b required 00100",
               {in_ready, imem_we, core_reset, done, error});
    end
    checks++;
    if ({imem_adr, imem_wdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_bus: got adr=%h wdata=%h required 0/0", imem_adr, imem_wdata);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    load_good_stream();
    wr_q.delete();
    send_stream(0, 9, 1'b0);
    checks++;
    if ({done, core_reset} !== 2'b01) begin
      errors++;
      $display("FAIL basic_pre_csum: got done/crst=%b required 01", {done, core_reset});
    end
    send_stream(10, 10, 1'b0);
    checks++;
    if ({done, core_reset, error, in_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL basic_done: got done/crst/err/rdy=%b required 1000",
               {done, core_reset, error, in_ready});
    end
    check_two_writes("basic");
    pulse_restart();
    checks++;
    if ({done, core_reset, in_ready} !== 3'b011) begin
      errors++;
      $display("FAIL basic_restart: got done/crst/rdy=%b required 011", {done, core_reset, in_ready});
    end
  endtask

  task automatic test_bad_checksum();
    load_good_stream();
    stream[10] = 8'hF5;
    wr_q.delete();
    send_stream(0, 10, 1'b0);
    checks++;
    if ({error, core_reset, done, in_ready} !== 4'b1100) begin
      errors++;
      $display("FAIL badcsum_err: got err/crst/done/rdy=%b required 1100",
               {error, core_reset, done, in_ready});
    end
    check_two_writes("badcsum");
    pulse_restart();
    checks++;
    if ({error, in_ready, core_reset} !== 3'b011) begin
      errors++;
      $display("FAIL badcsum_restart: got err/rdy/crst=%b required 011", {error, in_ready, core_reset});
    end
  endtask

  task automatic test_zero_words();
    stream = '{8'h00, 8'h00, 8'h00};
    wr_q.delete();
    send_stream(0, 2, 1'b0);
    checks++;
    if ({done, core_reset} !== 2'b10) begin
      errors++;
      $display("FAIL zero_done: got done/crst=%b required 10", {done, core_reset});
    end
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if ({done, in_ready, 32'(wr_q.size())} !== {2'b10, 32'd0}) begin
      errors++;
      $display("FAIL zero_hold: got done=%b rdy=%b writes=%0d required 1/0/0", done, in_ready, wr_q.size());
    end
    pulse_restart();
  endtask

  task automatic test_oversize();
    stream = '{8'h01, 8'h04};
    wr_q.delete();
    send_stream(0, 1, 1'b0);
    checks++;
    if ({error, in_ready, core_reset, 32'(wr_q.size())} !== {3'b101, 32'd0}) begin
      errors++;
      $display("FAIL oversize: got err=%b rdy=%b crst=%b writes=%0d required 1/0/1/0",
               error, in_ready, core_reset, wr_q.size());
    end
    pulse_restart();
    checks++;
    if ({error, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL oversize_restart: got err/rdy=%b required 01", {error, in_ready});
    end
  endtask

  task automatic test_max_words();
    stream = '{8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
    wr_q.delete();
    send_stream(0, 1, 1'b0);
    checks++;
    if ({error, in_ready, core_reset} !== 3'b011) begin
      errors++;
      $display("FAIL max_words_legal: got err/rdy/crst=%b required 011", {error, in_ready, core_reset});
    end
    pulse_restart();
    send_stream(2, 5, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (wr_q.size() !== 1 || wr_q[0] !== {32'h0, 32'h0403_0201}) begin
      errors++;
      $display("FAIL max_words_write: got n=%0d first=%h required 1 x %h",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 64'h0, {32'h0, 32'h0403_0201});
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_bubbles();
    load_good_stream();
    wr_q.delete();
    send_stream(0, 10, 1'b1);
    checks++;
    if ({done, error, core_reset} !== 3'b100) begin
      errors++;
      $display("FAIL bubbles_done: got done/err/crst=%b required 100", {done, error, core_reset});
    end
    check_two_writes("bubbles");
    pulse_restart();
  endtask

  task automatic test_reset_midload();
    load_good_stream();
    send_stream(0, 5, 1'b0);
    reset = 1'b0;
    #1;
    checks++;
    if ({imem_we, in_ready, core_reset, done, error} !== 5'b00100) begin
      errors++;
      $display("FAIL midload_reset: got we/rdy/crst/done/err=%b required 00100",
               {imem_we, in_ready, core_reset, done, error});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wr_q.delete();
    @(posedge clk);
    #1;
    send_stream(0, 10, 1'b0);
    checks++;
    if ({done, core_reset} !== 2'b10) begin
      errors++;
      $display("FAIL midload_done: got done/crst=%b required 10", {done, core_reset});
    end
    check_two_writes("midload");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_checksum();
    test_zero_words();
    test_oversize();
    test_max_words();
    test_bubbles();
    test_reset_midload();
    checks++;
    if (we_double !== 0) begin
      errors++;
      $display("FAIL we_single_cycle: got %0d multi-cycle strobes required 0", we_double);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
